// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters and mispredict detection.
// Optional BP_PERF_EN macro enables the lookup/mispredict performance counters.
module branch_predictor #(
   parameter int DATA_WIDTH = 32,
   parameter int ENTRIES = 16,
   parameter logic [1:0] CTR_INIT = 2'b10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] PCF,
   output logic                  PredTakenF,
   output logic [DATA_WIDTH-1:0] PredTargetF,
   input  logic                  UpdateE,
   input  logic [DATA_WIDTH-1:0] PCE,
   input  logic                  IsJumpE,
   input  logic                  ActualTakenE,
   input  logic [DATA_WIDTH-1:0] ActualTargetE,
   input  logic                  PredTakenE,
   input  logic [DATA_WIDTH-1:0] PredTargetE,
   output logic                  MispredictE,
   output logic [DATA_WIDTH-1:0] RecoverPCE,
   output logic [31:0]           LookupCount,
   output logic [31:0]           MispredictCount
);
   localparam int IDX = $clog2(ENTRIES);
   localparam int TW = DATA_WIDTH - IDX - 2;
   logic                  validQ  [ENTRIES];
   logic [TW-1:0]         tagQ    [ENTRIES];
   logic [DATA_WIDTH-1:0] targetQ [ENTRIES];
   logic [1:0]            ctrQ    [ENTRIES];
   logic [IDX-1:0] fIdx, eIdx;
   logic [TW-1:0]  fTag, eTag;
   logic           fHit, eHit;
   logic [1:0]     eCtr, nextCtr;
   always_comb begin
      fIdx = PCF[IDX+1:2];
      fTag = PCF[DATA_WIDTH-1:IDX+2];
      fHit = validQ[fIdx] && (tagQ[fIdx] == fTag);
      PredTakenF = fHit & ctrQ[fIdx][1];
      PredTargetF = PredTakenF ? targetQ[fIdx] : PCF + DATA_WIDTH'(4);
      eIdx = PCE[IDX+1:2];
      eTag = PCE[DATA_WIDTH-1:IDX+2];
      eHit = validQ[eIdx] && (tagQ[eIdx] == eTag);
      eCtr = ctrQ[eIdx];
      nextCtr = IsJumpE ? 2'b11
              : ActualTakenE ? ((eCtr == 2'b11) ? 2'b11 : eCtr + 2'd1)
              : ((eCtr == 2'b00) ? 2'b00 : eCtr - 2'd1);
      MispredictE = UpdateE & ((PredTakenE != ActualTakenE) | (ActualTakenE & (PredTargetE != ActualTargetE)));
      RecoverPCE = ActualTakenE ? ActualTargetE : PCE + DATA_WIDTH'(4);
   end
   // Not-taken misses leave the table alone; taken misses allocate over whatever occupies the slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            validQ[i] <= 1'b0;
            ctrQ[i] <= 2'b01;
         end
      end else if (UpdateE && (eHit || ActualTakenE)) begin
         validQ[eIdx] <= 1'b1;
         tagQ[eIdx] <= eTag;
         ctrQ[eIdx] <= eHit ? nextCtr : (IsJumpE ? 2'b11 : CTR_INIT);
         if (ActualTakenE) targetQ[eIdx] <= ActualTargetE;
      end
   end
`ifdef BP_PERF_EN
   logic [31:0] lookupQ, misQ;
   always_ff @(posedge clk) begin
      if (rst) begin
         lookupQ <= '0;
         misQ <= '0;
      end else begin
         if (UpdateE) lookupQ <= lookupQ + 32'd1;
         if (MispredictE) misQ <= misQ + 32'd1;
      end
   end
   assign LookupCount = lookupQ;
   assign MispredictCount = misQ;
`else
   assign LookupCount = 32'd0;
   assign MispredictCount = 32'd0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed checks of lookup, update, aliasing, jumps, reset and counters.
module tb_branch_predictor;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [31:0] PCF = '0, PCE = '0, ActualTargetE = '0, PredTargetE = '0;
   logic UpdateE = 1'b0, IsJumpE = 1'b0, ActualTakenE = 1'b0, PredTakenE = 1'b0;
   logic PredTakenF, MispredictE;
   logic [31:0] PredTargetF, RecoverPCE, LookupCount, MispredictCount;
   int compared = 0;
   int mismatched = 0;

   branch_predictor dut (
      .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
      .UpdateE(UpdateE), .PCE(PCE), .IsJumpE(IsJumpE), .ActualTakenE(ActualTakenE),
      .ActualTargetE(ActualTargetE), .PredTakenE(PredTakenE), .PredTargetE(PredTargetE),
      .MispredictE(MispredictE), .RecoverPCE(RecoverPCE),
      .LookupCount(LookupCount), .MispredictCount(MispredictCount)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic [31:0] pc, input logic jump, input logic taken,
                        input logic [31:0] tgt, input logic ptaken, input logic [31:0] ptgt);
      UpdateE = 1'b1; PCE = pc; IsJumpE = jump; ActualTakenE = taken;
      ActualTargetE = tgt; PredTakenE = ptaken; PredTargetE = ptgt;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      UpdateE = 1'b0; IsJumpE = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; PCF = 32'h100;
      #1;
      compared++; if (PredTakenF !== 1'b0) begin mismatched++; $display("FAIL reset_taken got %0b want 0", PredTakenF); end
      compared++; if (PredTargetF !== 32'h104) begin mismatched++; $display("FAIL reset_target got %h want 104", PredTargetF); end
      compared++; if (LookupCount !== 0 || MispredictCount !== 0) begin mismatched++; $display("FAIL reset_counts got %0d/%0d want 0/0", LookupCount, MispredictCount); end
      compared++; if (MispredictE !== 1'b0) begin mismatched++; $display("FAIL reset_mispredict got %0b want 0", MispredictE); end
   endtask

   task automatic test_allocate();
      PCF = 32'h100;
      drive(32'h100, 0, 1, 32'h80, 0, 32'h104);
      compared++; if (MispredictE !== 1'b1) begin mismatched++; $display("FAIL alloc_mispredict got %0b want 1", MispredictE); end
      compared++; if (RecoverPCE !== 32'h80) begin mismatched++; $display("FAIL alloc_recover got %h want 80", RecoverPCE); end
      compared++; if (PredTakenF !== 1'b0) begin mismatched++; $display("FAIL alloc_same_cycle got %0b want 0", PredTakenF); end
      step(); #1;
      compared++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h80) begin mismatched++; $display("FAIL alloc_lookup got %0b/%h want 1/80", PredTakenF, PredTargetF); end
   endtask

   task automatic test_counter();
      PCF = 32'h100;
      drive(32'h100, 0, 0, 32'h0, 1, 32'h80);
      compared++; if (MispredictE !== 1'b1 || RecoverPCE !== 32'h104) begin mismatched++; $display("FAIL nt_recover got %0b/%h want 1/104", MispredictE, RecoverPCE); end
      step(); #1;
      compared++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h104) begin mismatched++; $display("FAIL ctr_01 got %0b/%h want 0/104", PredTakenF, PredTargetF); end
      drive(32'h100, 0, 0, 32'h0, 0, 32'h104);
      compared++; if (MispredictE !== 1'b0) begin mismatched++; $display("FAIL nt_correct got %0b want 0", MispredictE); end
      step();
      for (int i = 0; i < 3; i++) begin drive(32'h100, 0, 0, 32'h0, 0, 32'h104); step(); end
      #1;
      compared++; if (PredTakenF !== 1'b0) begin mismatched++; $display("FAIL ctr_00_hold got %0b want 0", PredTakenF); end
      drive(32'h100, 0, 1, 32'h80, 0, 32'h104); step(); #1;
      compared++; if (PredTakenF !== 1'b0) begin mismatched++; $display("FAIL ctr_00_to_01 got %0b want 0", PredTakenF); end
      drive(32'h100, 0, 1, 32'h80, 0, 32'h104); step(); #1;
      compared++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h80) begin mismatched++; $display("FAIL ctr_01_to_10 got %0b/%h want 1/80", PredTakenF, PredTargetF); end
   endtask

   task automatic test_alias();
      PCF = 32'h140; #1;
      compared++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h144) begin mismatched++; $display("FAIL alias_miss got %0b/%h want 0/144", PredTakenF, PredTargetF); end
      drive(32'h140, 0, 1, 32'h20, 0, 32'h144); step();
      PCF = 32'h100; #1;
      compared++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h104) begin mismatched++; $display("FAIL alias_evicted got %0b/%h want 0/104", PredTakenF, PredTargetF); end
      PCF = 32'h140; #1;
      compared++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h20) begin mismatched++; $display("FAIL alias_new got %0b/%h want 1/20", PredTakenF, PredTargetF); end
   endtask

   task automatic test_jump();
      PCF = 32'h200;
      drive(32'h200, 1, 1, 32'h300, 0, 32'h204); step();
      drive(32'h200, 0, 0, 32'h0, 1, 32'h300);
      compared++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h300) begin mismatched++; $display("FAIL jump_same_cycle got %0b/%h want 1/300", PredTakenF, PredTargetF); end
      step(); #1;
      compared++; if (PredTakenF !== 1'b1 || PredTargetF !== 32'h300) begin mismatched++; $display("FAIL jump_ctr_10 got %0b/%h want 1/300", PredTakenF, PredTargetF); end
      drive(32'h200, 0, 0, 32'h0, 1, 32'h300); step(); #1;
      compared++; if (PredTakenF !== 1'b0) begin mismatched++; $display("FAIL jump_ctr_01 got %0b want 0", PredTakenF); end
      drive(32'h200, 1, 1, 32'h300, 0, 32'h204); step();
      drive(32'h200, 0, 0, 32'h0, 1, 32'h300); step(); #1;
      compared++; if (PredTakenF !== 1'b1) begin mismatched++; $display("FAIL jump_hit_forces_11 got %0b want 1", PredTakenF); end
   endtask

   task automatic test_no_update();
      UpdateE = 1'b0; PredTakenE = 1'b1; ActualTakenE = 1'b0; PCE = 32'hFFFF_FFFC; PCF = 32'hFFFF_FFFC;
      #1;
      compared++; if (MispredictE !== 1'b0) begin mismatched++; $display("FAIL idle_mispredict got %0b want 0", MispredictE); end
      compared++; if (RecoverPCE !== 32'h0 || PredTargetF !== 32'h0) begin mismatched++; $display("FAIL wrap got %h/%h want 0/0", RecoverPCE, PredTargetF); end
      drive(32'hFFFF_FFFC, 0, 0, 32'h0, 0, 32'h0); step(); #1;
      compared++; if (PredTakenF !== 1'b0) begin mismatched++; $display("FAIL nt_miss_no_alloc got %0b want 0", PredTakenF); end
   endtask

   task automatic test_perf();
      rst = 1'b1; @(posedge clk); @(negedge clk); rst = 1'b0;
      drive(32'h100, 0, 1, 32'h80, 0, 32'h104);
      compared++; if (MispredictE !== 1'b1) begin mismatched++; $display("FAIL perf_u1 got %0b want 1", MispredictE); end
      step();
      drive(32'h100, 0, 1, 32'h80, 1, 32'h80);
      compared++; if (MispredictE !== 1'b0) begin mismatched++; $display("FAIL perf_u2 got %0b want 0", MispredictE); end
      step();
      drive(32'h100, 0, 1, 32'h90, 1, 32'h80);
      compared++; if (MispredictE !== 1'b1) begin mismatched++; $display("FAIL perf_target got %0b want 1", MispredictE); end
      step();
      drive(32'h104, 0, 0, 32'h0, 0, 32'h108); step();
      drive(32'h108, 0, 0, 32'h0, 0, 32'h10C); step(); #1;
`ifdef BP_PERF_EN
      compared++; if (LookupCount !== 5 || MispredictCount !== 2) begin mismatched++; $display("FAIL perf_counts got %0d/%0d want 5/2", LookupCount, MispredictCount); end
`else
      compared++; if (LookupCount !== 0 || MispredictCount !== 0) begin mismatched++; $display("FAIL perf_tied got %0d/%0d want 0/0", LookupCount, MispredictCount); end
`endif
      rst = 1'b1;
      drive(32'h10C, 0, 1, 32'h40, 0, 32'h110);
      step(); rst = 1'b0; #1;
      compared++; if (LookupCount !== 0 || MispredictCount !== 0) begin mismatched++; $display("FAIL perf_cleared got %0d/%0d want 0/0", LookupCount, MispredictCount); end
      PCF = 32'h100; #1;
      compared++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h104) begin mismatched++; $display("FAIL post_reset_100 got %0b/%h want 0/104", PredTakenF, PredTargetF); end
      PCF = 32'h10C; #1;
      compared++; if (PredTakenF !== 1'b0 || PredTargetF !== 32'h110) begin mismatched++; $display("FAIL reset_beats_update got %0b/%h want 0/110", PredTakenF, PredTargetF); end
   endtask

   initial begin
      test_reset();
      test_allocate();
      test_counter();
      test_alias();
      test_jump();
      test_no_update();
      test_perf();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, address/target width.
REQ-002 SHALL have parameter ENTRIES, default 16, table depth; power of two, >= 2; IDX = log2(ENTRIES).
REQ-003 SHALL have parameter CTR_INIT, default 2'b10, counter value written on a new allocation.
REQ-004 SHALL have ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- PCF  in  DATA_WIDTH  fetch-stage PC for lookup.
- PredTakenF  out  1  prediction: redirect fetch.
- PredTargetF  out  DATA_WIDTH  predicted next PC.
- UpdateE  in  1  a resolved, unflushed branch or jump is in execute.
- PCE  in  DATA_WIDTH  PC of that instruction.
- IsJumpE  in  1  instruction is an unconditional jump.
- ActualTakenE  in  1  resolved direction.
- ActualTargetE  in  DATA_WIDTH  resolved target.
- PredTakenE  in  1  prediction carried down the pipeline with the instruction.
- PredTargetE  in  DATA_WIDTH  predicted target carried down the pipeline.
- MispredictE  out  1  flush request to the hazard unit.
- RecoverPCE  out  DATA_WIDTH  correct next PC on mispredict.
- LookupCount  out  32  resolved-update counter.
- MispredictCount  out  32  mispredict counter.

Function
REQ-005 SHALL hold ENTRIES entries; each entry holds valid, tag, target and a 2-bit saturating counter.
REQ-006 SHALL index with PC[IDX+1:2] and tag with PC[DATA_WIDTH-1:IDX+2]; PC[1:0] are ignored.
REQ-007 Lookup SHALL be combinational: hit = valid & tag match; PredTakenF = hit & ctr[1]; PredTargetF = target when PredTakenF, else PCF+4.
REQ-008 On UpdateE with a hit at PCE:
- counter +1 (saturating at 3) if taken, -1 (saturating at 0) if not taken;
- target overwritten with ActualTargetE when taken.
REQ-009 On UpdateE with a miss and ActualTakenE=1, the entry SHALL be replaced: valid=1, new tag, target=ActualTargetE, ctr=CTR_INIT.
REQ-010 On UpdateE with a miss and ActualTakenE=0, table state SHALL NOT change.
REQ-011 When IsJumpE=1, the counter SHALL be written to 2'b11 regardless of its prior value.
REQ-012 A same-cycle lookup and update of the same index SHALL return pre-update contents; the update is visible from the next cycle.
REQ-013 MispredictE = UpdateE & ((PredTakenE != ActualTakenE) | (ActualTakenE & PredTargetE != ActualTargetE)); combinational.
REQ-014 RecoverPCE = ActualTakenE ? ActualTargetE : PCE+4; combinational.
REQ-015 With UpdateE=0, table state SHALL be unchanged and MispredictE=0.
REQ-016 PC+4 arithmetic SHALL be DATA_WIDTH wide; carry-out is discarded (wraps).

Reset
REQ-017 rst=1 at a clock edge SHALL clear every valid bit and set every counter to 2'b01; target and tag contents are don't-care.
REQ-018 rst SHALL take priority over a simultaneous UpdateE; a reset mid-operation discards that update.
REQ-019 After reset, PredTakenF=0 and PredTargetF=PCF+4 for every PCF; LookupCount=0 and MispredictCount=0.

Configuration
REQ-020 Macro BP_PERF_EN:
- defined: LookupCount increments on each UpdateE; MispredictCount increments on each MispredictE=1; both wrap mod 2^32 and clear on rst.
- undefined: both outputs tied to 0 and the counter registers are not synthesised; prediction behaviour is identical in both cases.

Verification
REQ-021 Reset, PCF=0x100 -> PredTakenF=0, PredTargetF=0x104.
REQ-022 UpdateE, PCE=0x100, taken, ActualTargetE=0x80, PredTakenE=0 -> MispredictE=1, RecoverPCE=0x80; next cycle PCF=0x100 -> PredTakenF=1, PredTargetF=0x80.
REQ-023 Continue from REQ-022 with two not-taken updates at 0x100 -> ctr 10->01->00, PredTakenF=0; three further not-taken updates hold 00; one taken update -> 01, PredTakenF still 0.
REQ-024 ENTRIES=16, entry at 0x100 valid, PCF=0x140 (same index, different tag) -> PredTakenF=0; taken update at 0x140 to target 0x20 evicts 0x100, after which PCF=0x100 misses.
REQ-025 Jump update at PCE=0x200 to 0x300, IsJumpE=1 -> ctr=11; then a same-cycle lookup of 0x200 with a not-taken update -> old prediction (taken, 0x300) that cycle, and ctr=10 after.
REQ-026 BP_PERF_EN defined: 5 updates with 2 mispredicts, then rst for one cycle -> counters read 5/2 before reset, 0/0 after reset, and every PCF misses.
